// File: rtl/tenbaset_tx_scheduler.sv
// tenbaset_tx_scheduler
//   Frame scheduler and arbiter in front of the 10BASE-T transmit core.
//   The transmitter is shared between NUM_SRC payload sources using
//   round-robin arbitration. For each frame the block:
//     - grants one source,
//     - pulses tx_start,
//     - steers that source's FWFT FIFO bytes into the core's payload window,
//     - then holds the inter-frame gap before arbitrating again.
//   Start timeouts, payload underruns and short frames are flagged with
//   one-cycle pulses.
//
// Ports
//   clk20, rst_n            20 MHz clock, async active-low reset
//   src_req/src_valid       per-source frame request / FIFO not-empty
//   src_data                per-source FIFO head byte, source i at [8i+7:8i]
//   src_pop                 per-source FIFO read strobe (granted source only)
//   grant                   one-hot owner of the current frame
//   tx_start                one-cycle frame start pulse to the core
//   tx_busy, tx_byte_rd     core busy level and per-byte load strobe
//   tx_data                 payload byte to the core (0x00 outside payload)
//   frame_done, underrun,   one-cycle status pulses
//   frame_short, start_timeout
//   sched_busy              high whenever the scheduler is not IDLE
module tenbaset_tx_scheduler #(
    parameter int NUM_SRC       = 2,
    parameter int HDR_BYTES     = 50,
    parameter int PAYLOAD_BYTES = 1472,
    parameter int IFG_CYCLES    = 192,
    parameter int START_TIMEOUT = 16
) (
    input  logic                   clk20,
    input  logic                   rst_n,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [8*NUM_SRC-1:0]   src_data,
    output logic [NUM_SRC-1:0]     src_pop,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   tx_start,
    input  logic                   tx_busy,
    input  logic                   tx_byte_rd,
    output logic [7:0]             tx_data,
    output logic                   frame_done,
    output logic                   underrun,
    output logic                   frame_short,
    output logic                   start_timeout,
    output logic                   sched_busy
);

    localparam int SW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int GW = $clog2(IFG_CYCLES + 1);
    localparam int TW = $clog2(START_TIMEOUT + 1);

    localparam logic [15:0]   WIN_LO    = 16'(HDR_BYTES);
    localparam logic [15:0]   WIN_HI    = 16'(HDR_BYTES + PAYLOAD_BYTES);
    localparam logic [GW-1:0] GAP_LAST  = GW'(IFG_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(START_TIMEOUT - 1);
    localparam logic [SW-1:0] LAST_INIT = SW'(NUM_SRC - 1);

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       last_q, last_d;          // also the granted index while a frame runs
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [15:0]         idx_q, idx_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic [TW-1:0]       to_q, to_d;
    logic                tx_start_q, tx_start_d;
    logic                frame_done_q, frame_done_d;
    logic                underrun_q, underrun_d;
    logic                frame_short_q, frame_short_d;
    logic                start_timeout_q, start_timeout_d;

    logic [SW-1:0]       win;
    logic [7:0]          g_byte;
    logic                g_valid;
    logic                payload_slot;

    // First requester found scanning last+1, last+2, ... modulo NUM_SRC.
    function automatic logic [SW-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                              input logic [SW-1:0]      last);
        logic [SW-1:0] pick;
        logic          found;
        int            c;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            c = (int'(last) + k) % NUM_SRC;
            if (!found && req[c]) begin
                found = 1'b1;
                pick  = SW'(c);
            end
        end
        return pick;
    endfunction

    assign win          = rr_pick(src_req, last_q);
    assign g_byte       = src_data[{last_q, 3'b000} +: 8];
    assign g_valid      = src_valid[last_q];
    assign payload_slot = (state_q == SEND) && (idx_q >= WIN_LO) && (idx_q < WIN_HI);

    // State register
    always_ff @(posedge clk20 or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            last_q          <= LAST_INIT;
            grant_q         <= '0;
            idx_q           <= '0;
            gap_q           <= '0;
            to_q            <= '0;
            tx_start_q      <= 1'b0;
            frame_done_q    <= 1'b0;
            underrun_q      <= 1'b0;
            frame_short_q   <= 1'b0;
            start_timeout_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            last_q          <= last_d;
            grant_q         <= grant_d;
            idx_q           <= idx_d;
            gap_q           <= gap_d;
            to_q            <= to_d;
            tx_start_q      <= tx_start_d;
            frame_done_q    <= frame_done_d;
            underrun_q      <= underrun_d;
            frame_short_q   <= frame_short_d;
            start_timeout_q <= start_timeout_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        grant_d         = grant_q;
        idx_d           = idx_q;
        gap_d           = gap_q;
        to_d            = to_q;
        tx_start_d      = 1'b0;
        frame_done_d    = 1'b0;
        underrun_d      = 1'b0;
        frame_short_d   = 1'b0;
        start_timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (|src_req) begin
                    last_d       = win;
                    grant_d      = '0;
                    grant_d[win] = 1'b1;
                    tx_start_d   = 1'b1;
                    to_d         = '0;
                    state_d      = START;
                end
            end
            START: begin
                to_d = to_q + 1'b1;
                if (tx_busy) begin
                    idx_d   = '0;
                    state_d = SEND;
                end else if (to_q == TO_LAST) begin
                    start_timeout_d = 1'b1;
                    grant_d         = '0;
                    gap_d           = '0;
                    state_d         = GAP;
                end
            end
            SEND: begin
                if (tx_byte_rd && idx_q != 16'hFFFF)
                    idx_d = idx_q + 16'd1;
                if (payload_slot && tx_byte_rd && !g_valid)
                    underrun_d = 1'b1;
                // A strobe in the falling cycle is already in idx_d, so it
                // counts toward completion before the short check.
                if (!tx_busy) begin
                    frame_done_d  = 1'b1;
                    frame_short_d = (idx_d < WIN_HI);
                    grant_d       = '0;
                    gap_d         = '0;
                    state_d       = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs; the payload path is combinational so a pop lands in the
    // same cycle as the core's load strobe.
    always_comb begin
        tx_data = 8'h00;
        src_pop = '0;
        if (payload_slot && g_valid) begin
            tx_data         = g_byte;
            src_pop[last_q] = tx_byte_rd;
        end
    end

    assign grant         = grant_q;
    assign tx_start      = tx_start_q;
    assign frame_done    = frame_done_q;
    assign underrun      = underrun_q;
    assign frame_short   = frame_short_q;
    assign start_timeout = start_timeout_q;
    assign sched_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_tenbaset_tx_scheduler.sv
// Directed bench for tenbaset_tx_scheduler. A small transmit-core model
// raises tx_busy on tx_start and issues one byte strobe per cycle; each
// source is an FWFT FIFO whose head byte counts up from 0x00 on every pop.
module tb_tenbaset_tx_scheduler;

    logic        clk20;
    logic        rst_n;
    logic [1:0]  src_req;
    logic [1:0]  src_valid;
    logic [15:0] src_data;
    logic [1:0]  src_pop;
    logic [1:0]  grant;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_byte_rd;
    logic [7:0]  tx_data;
    logic        frame_done;
    logic        underrun;
    logic        frame_short;
    logic        start_timeout;
    logic        sched_busy;

    tenbaset_tx_scheduler dut (
        .clk20         (clk20),
        .rst_n         (rst_n),
        .src_req       (src_req),
        .src_valid     (src_valid),
        .src_data      (src_data),
        .src_pop       (src_pop),
        .grant         (grant),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .tx_byte_rd    (tx_byte_rd),
        .tx_data       (tx_data),
        .frame_done    (frame_done),
        .underrun      (underrun),
        .frame_short   (frame_short),
        .start_timeout (start_timeout),
        .sched_busy    (sched_busy)
    );

    initial clk20 = 1'b0;
    always #5 clk20 = ~clk20;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int strobe = -1;
    int pops [2];
    logic [7:0] head [2];
    int starts, dones, shorts, unds, touts, bad_pops;
    int done_cyc, short_cyc, to_cyc;
    int first_pop, last_pop;
    logic [7:0] dlog [0:2047];

    assign src_data = {head[1], head[0]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        pops[0] = 0; pops[1] = 0;
        starts = 0; dones = 0; shorts = 0; unds = 0; touts = 0;
        done_cyc = -1; short_cyc = -1; to_cyc = -1;
        first_pop = -1; last_pop = -1;
    endtask

    // Called #2 after a rising edge with inputs already set; samples, then
    // advances to #2 after the next rising edge.
    task automatic cyc();
        #1;
        if (tx_start) starts++;
        if (frame_done) begin dones++; done_cyc = cyc_n; end
        if (frame_short) begin shorts++; short_cyc = cyc_n; end
        if (underrun) unds++;
        if (start_timeout) begin touts++; to_cyc = cyc_n; end
        if (((src_pop & ~grant) != 2'b00) || (src_pop != 2'b00 && !tx_byte_rd)) bad_pops++;
        if (tx_byte_rd && strobe >= 0 && strobe < 2048) dlog[strobe] = tx_data;
        for (int i = 0; i < 2; i++) begin
            if (src_pop[i]) begin
                pops[i]++;
                head[i] = head[i] + 8'd1;
                if (first_pop < 0) first_pop = strobe;
                last_pop = strobe;
            end
        end
        @(posedge clk20);
        #2;
        cyc_n++;
    endtask

    task automatic wait_start(output int sc);
        for (int i = 0; i < 600; i++) begin
            if (tx_start === 1'b1) break;
            cyc();
        end
        check("tx_start_seen", tx_start, 1);
        sc = cyc_n;
    endtask

    // Core model for one frame from the tx_start cycle onward.
    task automatic run_send(input int n, input int dlo, input int dhi,
                            input bit fall_last, input int gi, output int fall_c);
        fall_c = -1;
        tx_busy = 1'b1;
        cyc();
        for (int s = 0; s < n; s++) begin
            strobe     = s;
            tx_byte_rd = 1'b1;
            src_valid  = 2'b11;
            if (s >= dlo && s <= dhi) src_valid[gi] = 1'b0;
            if (fall_last && s == n - 1) begin
                tx_busy = 1'b0;
                fall_c  = cyc_n;
            end
            cyc();
        end
        strobe     = -1;
        tx_byte_rd = 1'b0;
        src_valid  = 2'b11;
        if (!fall_last) begin
            tx_busy = 1'b0;
            fall_c  = cyc_n;
            cyc();
        end
        repeat (3) cyc();
    endtask

    int sc, sc2, fc, gi, prev_done;

    initial begin
        rst_n = 1'b0; src_req = 2'b00; src_valid = 2'b11;
        tx_busy = 1'b0; tx_byte_rd = 1'b0;
        head[0] = 8'h00; head[1] = 8'h00;
        bad_pops = 0;
        clr_stats();
        repeat (3) @(posedge clk20);
        #2;

        // Reset state
        check("rst_grant", grant, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_sched_busy", sched_busy, 0);
        check("rst_src_pop", src_pop, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        cyc(); cyc();

        // Single source, last strobe coincides with tx_busy falling
        src_req = 2'b01;
        wait_start(sc);
        check("single_grant", grant, 2'b01);
        run_send(1522, -1, -1, 1'b1, 0, fc);
        check("single_starts", starts, 1);
        check("single_pops", pops[0], 1472);
        check("single_first_pop", first_pop, 50);
        check("single_last_pop", last_pop, 1521);
        check("single_data50", dlog[50], 8'h00);
        check("single_data1521", dlog[1521], 8'hBF);
        check("single_dones", dones, 1);
        check("single_done_cyc", done_cyc, fc + 1);
        check("single_no_short", shorts, 0);
        check("single_no_underrun", unds, 0);
        check("single_no_timeout", touts, 0);

        // Fairness from a fresh reset
        src_req = 2'b00;
        rst_n = 1'b0; cyc(); cyc(); rst_n = 1'b1;
        clr_stats();
        src_req = 2'b11;
        prev_done = 0;
        for (int f = 0; f < 4; f++) begin
            wait_start(sc);
            check($sformatf("fair_grant%0d", f), grant, (f % 2 == 0) ? 2'b01 : 2'b10);
            if (f > 0) check($sformatf("fair_gap%0d", f), (sc - prev_done) >= 193, 1);
            gi = grant[1] ? 1 : 0;
            run_send(1522, -1, -1, 1'b0, gi, fc);
            prev_done = done_cyc;
        end
        check("fair_pops0", pops[0], 2944);
        check("fair_pops1", pops[1], 2944);
        check("fair_dones", dones, 4);

        // Underrun on source 0, strobes 100..102
        src_req = 2'b01;
        clr_stats();
        wait_start(sc);
        check("und_grant", grant, 2'b01);
        run_send(1522, 100, 102, 1'b0, 0, fc);
        check("und_data100", dlog[100], 8'h00);
        check("und_data101", dlog[101], 8'h00);
        check("und_data102", dlog[102], 8'h00);
        check("und_pulses", unds, 3);
        check("und_pops", pops[0], 1469);
        check("und_no_short", shorts, 0);

        // Start timeout: core never goes busy
        clr_stats();
        wait_start(sc);
        check("to_grant", grant, 2'b01);
        repeat (20) cyc();
        check("to_pulses", touts, 1);
        check("to_delay", to_cyc - sc, 16);
        check("to_grant_clear", grant, 0);
        check("to_no_done", dones, 0);
        src_req = 2'b11;
        wait_start(sc2);
        check("to_gap", sc2 - to_cyc, 193);
        check("to_next_grant", grant, 2'b10);

        // Short frame on source 1: busy falls after 600 strobes
        clr_stats();
        run_send(600, -1, -1, 1'b0, 1, fc);
        check("short_dones", dones, 1);
        check("short_pulses", shorts, 1);
        check("short_same_cycle", short_cyc, done_cyc);
        check("short_done_cyc", done_cyc, fc + 1);
        check("short_pops1", pops[1], 550);
        check("short_pops0", pops[0], 0);

        // Reset in the middle of SEND
        src_req = 2'b01;
        wait_start(sc);
        check("mid_grant", grant, 2'b01);
        tx_busy = 1'b1;
        cyc();
        for (int s = 0; s < 300; s++) begin
            strobe = s; tx_byte_rd = 1'b1;
            cyc();
        end
        strobe = 300; tx_byte_rd = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_grant", grant, 0);
        check("mid_rst_pop", src_pop, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_busy", sched_busy, 0);
        @(posedge clk20);
        #2;
        cyc_n++;
        clr_stats();
        strobe = -1;
        cyc();
        tx_byte_rd = 1'b0; tx_busy = 1'b0;
        cyc();
        rst_n = 1'b1;
        src_req = 2'b11;
        wait_start(sc);
        check("mid_no_done", dones, 0);
        check("mid_no_pops", pops[0] + pops[1], 0);
        check("mid_prio_grant", grant, 2'b01);

        check("no_stray_pops", bad_pops, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
